// File: rtl/mp_pkg.sv
// Shared definitions for the multi-core processor: data-memory arbiter state
// encoding and the default core count / word width used across the datapath.
package mp_pkg;

  localparam int MP_NUM_CORES = 4;
  localparam int MP_WORD_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } dm_arb_state_t;

  // Index increment with wrap, used to advance the round-robin pointer.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping
// from the top index back to 0.
module rr_picker
  import mp_pkg::*;
#(
  parameter int NUM_CORES = MP_NUM_CORES,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  logic [IDX_W-1:0] pos;

  // Scan from farthest to nearest so the candidate closest to ptr is kept last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      pos   = IDX_W'((int'(ptr) + k) % NUM_CORES);
      idx   = req[pos] ? pos : idx;
      valid = valid | req[pos];
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between cores.
// One transaction at a time: IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> DONE.
module dm_arbiter
  import mp_pkg::*;
#(
  parameter int NUM_CORES = MP_NUM_CORES,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = MP_WORD_W,
  parameter int MEM_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_done,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        busy,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  dm_arb_state_t     state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  cur;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] addr_arr  [NUM_CORES];
  logic [DATA_W-1:0] wdata_arr [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign addr_arr[g]  = core_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = core_wdata[g*DATA_W +: DATA_W];
  end

  rr_picker #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req   (core_req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  function automatic logic [NUM_CORES-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(NUM_CORES-1){1'b0}}, 1'b1} << i;
  endfunction

  // Transaction FSM; every output is a register so nothing from core_* reaches
  // an output combinationally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur        <= '0;
      wait_cnt   <= '0;
      core_gnt   <= '0;
      core_done  <= '0;
      core_rdata <= '0;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            cur       <= pick_idx;
            mem_we    <= core_we[pick_idx];
            mem_addr  <= addr_arr[pick_idx];
            mem_wdata <= wdata_arr[pick_idx];
            core_gnt  <= onehot(pick_idx);
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ACCESS;
          end else begin
            state     <= IDLE;
          end
        end
        ACCESS: begin
          core_gnt <= '0;
          mem_en   <= 1'b0;
          wait_cnt <= CNT_W'(MEM_LAT);
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - CNT_W'(1);
          // Last wait cycle: read data is valid on the memory port now.
          if (wait_cnt == CNT_W'(1)) begin
            if (!mem_we) begin
              core_rdata <= mem_rdata;
            end else begin
              core_rdata <= core_rdata;
            end
            core_done <= onehot(cur);
            state     <= DONE;
          end else begin
            state     <= WAIT;
          end
        end
        DONE: begin
          core_done <= '0;
          rr_ptr    <= IDX_W'(wrap_inc(int'(cur), NUM_CORES));
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          core_gnt  <= '0;
          core_done <= '0;
          mem_en    <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
